// File: rtl/mult_arbiter_if.sv
// Requester-side and multiplier-side signals of the round-robin multiplier arbiter.
// The slave modport is the arbiter's view; master is the clients plus the multiplier.
interface mult_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ*32-1:0] req_a;
   logic [NUM_REQ*32-1:0] req_b;
   logic [NUM_REQ-1:0]    req_ack;
   logic [NUM_REQ-1:0]    resp_valid;
   logic [NUM_REQ-1:0]    resp_ready;
   logic [63:0]           resp_product;
   logic [ID_W-1:0]       resp_id;
   logic                  arb_busy;
   logic                  mult_start;
   logic [31:0]           mult_a;
   logic [31:0]           mult_b;
   logic                  mult_busy;
   logic [63:0]           mult_product;

   modport slave (
      input  req, req_a, req_b, resp_ready, mult_busy, mult_product,
      output req_ack, resp_valid, resp_product, resp_id, arb_busy,
             mult_start, mult_a, mult_b
   );

   modport master (
      output req, req_a, req_b, resp_ready, mult_busy, mult_product,
      input  req_ack, resp_valid, resp_product, resp_id, arb_busy,
             mult_start, mult_a, mult_b
   );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential 32x32 multiplier between NUM_REQ clients.
// Operands are latched at grant, so the multiplier never sees client-side changes.
module mult_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic          clk,
   input  logic          reset,
   mult_arbiter_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_RUN,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [ID_W-1:0]     r_last_grant;
   logic [ID_W-1:0]     r_resp_id;
   logic [31:0]         r_a;
   logic [31:0]         r_b;
   logic [63:0]         r_resp_product;
   logic [NUM_REQ-1:0]  r_req_ack;
   logic [NUM_REQ-1:0]  r_resp_valid;
   logic                r_mult_start;
   logic                r_arb_busy;

   logic                w_found;
   logic [ID_W-1:0]     w_grant;
   logic [ID_W-1:0]     w_cand;

   // Scan starts one past the last grant, so the last winner ends up lowest priority.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path holds a stale value (no latch).
      w_found = 1'b0;
      w_grant = '0;
      w_cand  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
         if (!w_found && bus.req[w_cand]) begin
            w_found = 1'b1;
            w_grant = w_cand;
         end
      end
   end

   // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_last_grant   <= ID_W'(NUM_REQ - 1);
         r_resp_id      <= '0;
         r_a            <= '0;
         r_b            <= '0;
         r_resp_product <= '0;
         r_req_ack      <= '0;
         r_resp_valid   <= '0;
         r_mult_start   <= 1'b0;
         r_arb_busy     <= 1'b0;
      end else begin
         r_req_ack    <= '0;
         r_mult_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_resp_id    <= w_grant;
                  r_last_grant <= w_grant;
                  r_a          <= bus.req_a[32*w_grant +: 32];
                  r_b          <= bus.req_b[32*w_grant +: 32];
                  r_req_ack    <= NUM_REQ'(1) << w_grant;
                  r_mult_start <= 1'b1;
                  r_arb_busy   <= 1'b1;
                  r_state      <= S_LAUNCH;
               end
            end
            S_LAUNCH: r_state <= S_WAIT_BUSY;
            S_WAIT_BUSY: begin
               if (bus.mult_busy) r_state <= S_RUN;
            end
            S_RUN: begin
               if (!bus.mult_busy) begin
                  r_resp_product <= bus.mult_product;
                  r_resp_valid   <= NUM_REQ'(1) << r_resp_id;
                  r_state        <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.resp_ready[r_resp_id]) begin
                  r_resp_valid <= '0;
                  r_arb_busy   <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ack      = r_req_ack;
   assign bus.resp_valid   = r_resp_valid;
   assign bus.resp_product = r_resp_product;
   assign bus.resp_id      = r_resp_id;
   assign bus.arb_busy     = r_arb_busy;
   assign bus.mult_start   = r_mult_start;
   assign bus.mult_a       = r_a;
   assign bus.mult_b       = r_b;
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and randomized bench for mult_arbiter with a behavioural multiplier
// and a queue-free round-robin reference model.
module tb_mult_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mult_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();
   mult_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int ack_cnt[NUM_REQ] = '{default: 0};
   int ack_total = 0;
   int start_cnt = 0;
   int mult_lat  = 3;
   int m_cnt;
   logic [63:0] m_pend;
   logic [31:0] op_a[NUM_REQ];
   logic [31:0] op_b[NUM_REQ];

   // Behavioural multiplier: busy the edge after start, product on the edge busy falls.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.mult_busy    <= 1'b0;
         bus.mult_product <= '0;
         m_cnt            <= 0;
         m_pend           <= '0;
      end else if (bus.mult_busy) begin
         if (m_cnt == 0) begin
            bus.mult_busy    <= 1'b0;
            bus.mult_product <= m_pend;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end else if (bus.mult_start) begin
         bus.mult_busy <= 1'b1;
         m_cnt         <= mult_lat;
         m_pend        <= 64'(bus.mult_a) * 64'(bus.mult_b);
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (bus.req_ack[i] === 1'b1) begin
            ack_cnt[i]++;
            ack_total++;
         end
      end
      if (bus.mult_start === 1'b1) start_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NUM_REQ-1:0] onehot(input int i);
      return NUM_REQ'(1) << i;
   endfunction

   function automatic int pick(input bit pend[NUM_REQ], input int last);
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (pend[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
      end
      return 0;
   endfunction

   task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
      op_a[i] = a;
      op_b[i] = b;
      bus.req_a[32*i +: 32] = a;
      bus.req_b[32*i +: 32] = b;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " req_ack"},      bus.req_ack, 0);
      check({tag, " resp_valid"},   bus.resp_valid, 0);
      check({tag, " mult_start"},   bus.mult_start, 0);
      check({tag, " arb_busy"},     bus.arb_busy, 0);
      check({tag, " resp_product"}, bus.resp_product, 0);
      check({tag, " resp_id"},      bus.resp_id, 0);
      check({tag, " mult_a"},       bus.mult_a, 0);
      check({tag, " mult_b"},       bus.mult_b, 0);
   endtask

   // One full transaction for requester id; raise_mask requests appear right after the ack.
   task automatic run_txn(input int id, input logic [63:0] exp_p, input int ready_delay,
                          input logic [NUM_REQ-1:0] raise_mask, input string tag);
      bit got;
      bit stable;
      bit held;
      int s0;
      int a0;
      logic [31:0] ea;
      logic [31:0] eb;
      ea  = op_a[id];
      eb  = op_b[id];
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
         @(posedge clk); #1;
         if (bus.req_ack != 0) got = 1'b1;
      end
      check({tag, " ack_seen"},   got, 1);
      check({tag, " ack_onehot"}, bus.req_ack, onehot(id));
      check({tag, " start"},      bus.mult_start, 1);
      check({tag, " grant_id"},   bus.resp_id, id);
      bus.req[id] = 1'b0;
      bus.req_a[32*id +: 32] = $urandom;
      bus.req_b[32*id +: 32] = $urandom;
      bus.req = bus.req | raise_mask;
      stable = (bus.mult_a === ea) && (bus.mult_b === eb);
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(posedge clk); #1;
         if (bus.resp_valid != 0) got = 1'b1;
         else if (bus.mult_a !== ea || bus.mult_b !== eb) stable = 1'b0;
      end
      check({tag, " valid_seen"},   got, 1);
      check({tag, " valid_onehot"}, bus.resp_valid, onehot(id));
      check({tag, " product"},      bus.resp_product, exp_p);
      check({tag, " resp_id"},      bus.resp_id, id);
      check({tag, " ops_stable"},   stable, 1);
      s0   = start_cnt;
      a0   = ack_total;
      held = 1'b1;
      bus.resp_ready = ~onehot(id);
      for (int k = 0; k < ready_delay; k++) begin
         @(posedge clk); #1;
         if (bus.resp_valid !== onehot(id) || bus.resp_product !== exp_p) held = 1'b0;
      end
      check({tag, " held"},         held, 1);
      check({tag, " no_new_start"}, start_cnt, s0);
      check({tag, " no_new_ack"},   ack_total, a0);
      bus.resp_ready = onehot(id);
      @(posedge clk); #1;
      check({tag, " valid_cleared"}, bus.resp_valid, 0);
      check({tag, " back_idle"},     bus.arb_busy, 0);
      bus.resp_ready = '0;
   endtask

   initial begin
      bit pend[NUM_REQ];
      bit got;
      bit any;
      int s_before;
      int a1;
      int last_model;
      int w;

      reset          = 1'b1;
      bus.req        = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
         pend[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      check_zero("reset");

      // All four at once from reset: grants 0,1,2,3, one ack each.
      for (int i = 0; i < NUM_REQ; i++) set_ops(i, 32'(i + 2), 32'(i + 7));
      bus.req = '1;
      run_txn(0, 64'd14, 0, '0, "all4_r0");
      run_txn(1, 64'd24, 0, '0, "all4_r1");
      run_txn(2, 64'd36, 0, '0, "all4_r2");
      run_txn(3, 64'd50, 0, '0, "all4_r3");
      for (int i = 0; i < NUM_REQ; i++) check($sformatf("all4 ack_once%0d", i), ack_cnt[i], 1);

      // Single requester 1.
      s_before = start_cnt;
      set_ops(1, 32'd3, 32'd5);
      bus.req[1] = 1'b1;
      run_txn(1, 64'd15, 3, '0, "single_r1");
      check("single start_once", start_cnt, s_before + 1);
      check("single ack_once",   ack_cnt[1], 2);

      // Largest operands; req_a is scrambled after the ack inside run_txn.
      set_ops(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      bus.req[0] = 1'b1;
      run_txn(0, 64'hFFFF_FFFE_0000_0001, 2, '0, "max_r0");

      // Fairness: after a grant to 2, pending 1 and 3 resolve to 3 first.
      set_ops(2, 32'd11, 32'd13);
      set_ops(1, 32'd100, 32'd200);
      set_ops(3, 32'h1_0000, 32'h1_0000);
      bus.req[2] = 1'b1;
      run_txn(2, 64'd143, 0, 4'b1010, "fair_r2");
      run_txn(3, 64'h1_0000_0000, 1, '0, "fair_r3");
      run_txn(1, 64'd20000, 0, '0, "fair_r1");

      // Back-pressure: 20 cycles without ready while requester 2 waits.
      set_ops(0, 32'd7, 32'd9);
      set_ops(2, 32'd1000, 32'd1000);
      bus.req[0] = 1'b1;
      run_txn(0, 64'd63, 20, 4'b0100, "bp_r0");
      run_txn(2, 64'd1000000, 0, '0, "bp_r2");

      // Reset while the multiplier is running.
      mult_lat = 8;
      set_ops(1, 32'd5, 32'd6);
      bus.req[1] = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
         @(posedge clk); #1;
         if (bus.req_ack != 0) got = 1'b1;
      end
      check("rst ack_seen", got, 1);
      bus.req[1] = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
         @(posedge clk); #1;
         if (bus.mult_busy === 1'b1) got = 1'b1;
      end
      check("rst busy_seen", got, 1);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check_zero("midrst");
      a1 = ack_cnt[1];
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      mult_lat = 2;
      @(posedge clk); #1;
      check("post_rst resp_valid", bus.resp_valid, 0);
      check("post_rst arb_busy",   bus.arb_busy, 0);
      set_ops(0, 32'd2, 32'd3);
      set_ops(2, 32'd4, 32'd5);
      bus.req[0] = 1'b1;
      bus.req[2] = 1'b1;
      run_txn(0, 64'd6, 0, '0, "post_rst_r0");
      run_txn(2, 64'd20, 1, '0, "post_rst_r2");
      check("post_rst no_reack_r1", ack_cnt[1], a1);

      // Randomized traffic against the round-robin reference model.
      last_model = 2;
      for (int t = 0; t < 24; t++) begin
         any = 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               set_ops(i, $urandom, $urandom);
               bus.req[i] = 1'b1;
               pend[i]    = 1'b1;
            end
            if (pend[i]) any = 1'b1;
         end
         if (!any) begin
            w = int'($urandom_range(0, NUM_REQ - 1));
            set_ops(w, $urandom, $urandom);
            bus.req[w] = 1'b1;
            pend[w]    = 1'b1;
         end
         w        = pick(pend, last_model);
         mult_lat = int'($urandom_range(0, 5));
         run_txn(w, 64'(op_a[w]) * 64'(op_b[w]), int'($urandom_range(0, 3)), '0,
                 $sformatf("rnd%0d_r%0d", t, w));
         pend[w]    = 1'b0;
         last_model = w;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
